reaction_round_ctrl: RTL and testbench

Round controller for the reaction-time game. It schedules one 16-bit equality comparator, which is instantiated outside this block. The controller first holds off for a pseudo-random delay, then lights the cue LED and measures the player's reaction in millisecond ticks. It also detects early presses (fouls) and no-response timeouts. It sits between the start/button inputs and the score display, and it is the only driver of the comparator's operands.

---
 rtl/reaction_round_ctrl_if.sv | 25 ++
 rtl/reaction_round_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the reaction round controller and the rest of the game:
// start/button inputs, the shared equality comparator, and the cue/score outputs.
interface reaction_round_ctrl_if;
  logic        start;
  logic        button;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic        cmp_eq;
  logic        led;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
  logic        foul;
  logic        timeout;

  modport slave (
    input  start, button, cmp_eq,
    output cmp_a, cmp_b, led, busy, result, result_valid, foul, timeout
  );

  modport master (
    output start, button, cmp_eq,
    input  cmp_a, cmp_b, led, busy, result, result_valid, foul, timeout
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Reaction-time round controller: random hold-off, cue LED, reaction measurement
// in ms ticks, foul and timeout detection, time-shared use of one external comparator.
module reaction_round_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 1000,
  parameter int RAND_BITS = 11,
  parameter int MAX_REACT = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  reaction_round_ctrl_if.slave bus
);

  localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [15:0]      MIN_D16   = 16'(MIN_DELAY);
  localparam logic [15:0]      MAX_R16   = 16'(MAX_REACT);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REACT = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_ms;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_target;
  logic             r_button_q;
  logic             r_led;
  logic             r_busy;
  logic [15:0]      r_result;
  logic             r_result_valid;
  logic             r_foul;
  logic             r_timeout;

  logic             w_tick;
  logic             w_press;
  logic             w_lfsr_fb;
  logic [15:0]      w_target_nxt;
  logic             w_clr_cnt;
  logic             w_load_target;
  logic             w_led_nxt;
  logic             w_busy_nxt;
  logic [15:0]      w_result_nxt;
  logic             w_result_valid_nxt;
  logic             w_foul_nxt;
  logic             w_timeout_nxt;
  logic [15:0]      w_cmp_a;
  logic [15:0]      w_cmp_b;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_press      = bus.button & ~r_button_q;
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_target_nxt = MIN_D16 + {{(16-RAND_BITS){1'b0}}, r_lfsr[RAND_BITS-1:0]};

  // Next state, next registered outputs and comparator operand selection
  always_comb begin
    w_state_nxt        = r_state;
    w_led_nxt          = r_led;
    w_busy_nxt         = r_busy;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    w_foul_nxt         = r_foul;
    w_timeout_nxt      = r_timeout;
    w_clr_cnt          = 1'b0;
    w_load_target      = 1'b0;
    w_cmp_a            = 16'd0;
    w_cmp_b            = 16'd0;
    case (r_state)
      S_WAIT: begin
        w_cmp_a = r_ms;
        w_cmp_b = r_target;
        if (w_press) begin
          w_state_nxt = S_FOUL;
          w_foul_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (bus.cmp_eq) begin
          w_state_nxt = S_REACT;
          w_led_nxt   = 1'b1;
          w_clr_cnt   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_REACT: begin
        w_cmp_a = r_ms;
        w_cmp_b = MAX_R16;
        // A press wins over the timeout compare, so a press on the last tick still scores
        if (w_press) begin
          w_state_nxt        = S_DONE;
          w_result_nxt       = r_ms;
          w_result_valid_nxt = 1'b1;
          w_led_nxt          = 1'b0;
          w_busy_nxt         = 1'b0;
        end else if (bus.cmp_eq) begin
          w_state_nxt        = S_DONE;
          w_result_nxt       = MAX_R16;
          w_result_valid_nxt = 1'b1;
          w_timeout_nxt      = 1'b1;
          w_led_nxt          = 1'b0;
          w_busy_nxt         = 1'b0;
        end else begin
          w_state_nxt = S_REACT;
        end
      end
      S_IDLE, S_DONE, S_FOUL: begin
        if (bus.start) begin
          w_state_nxt        = S_WAIT;
          w_busy_nxt         = 1'b1;
          w_led_nxt          = 1'b0;
          w_result_nxt       = 16'd0;
          w_result_valid_nxt = 1'b0;
          w_foul_nxt         = 1'b0;
          w_timeout_nxt      = 1'b0;
          w_clr_cnt          = 1'b1;
          w_load_target      = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_led          <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= 16'd0;
      r_result_valid <= 1'b0;
      r_foul         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_led          <= w_led_nxt;
      r_busy         <= w_busy_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_foul         <= w_foul_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  // Millisecond timebase, free-running LFSR, latched target and button history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= DIV_ZERO;
      r_ms       <= 16'd0;
      r_lfsr     <= LFSR_SEED;
      r_target   <= 16'd0;
      r_button_q <= 1'b0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      r_button_q <= bus.button;
      if (w_load_target) begin
        r_target <= w_target_nxt;
      end else begin
        r_target <= r_target;
      end
      if (w_clr_cnt) begin
        r_div <= DIV_ZERO;
        r_ms  <= 16'd0;
      end else if (w_tick) begin
        r_div <= DIV_ZERO;
        if (r_ms != 16'hFFFF) begin
          r_ms <= r_ms + 16'd1;
        end else begin
          r_ms <= r_ms;
        end
      end else begin
        r_div <= r_div + DIV_ONE;
      end
    end
  end

  assign bus.cmp_a        = w_cmp_a;
  assign bus.cmp_b        = w_cmp_b;
  assign bus.led          = r_led;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.foul         = r_foul;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: timestamp-based round model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_reaction_round_ctrl;
  localparam int TD   = 4;
  localparam int MIND = 3;
  localparam int RB   = 2;
  localparam int MAXR = 20;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_REACT = 2;
  localparam int P_DONE  = 3;
  localparam int P_FOUL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  reaction_round_ctrl_if bus();
  assign bus.cmp_eq = (bus.cmp_a == bus.cmp_b);

  reaction_round_ctrl #(
    .TICK_DIV (TD),
    .MIN_DELAY(MIND),
    .RAND_BITS(RB),
    .MAX_REACT(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: a round is described by its phase, the edge index where the ms count
  // was last cleared, and the latched target; ms is derived from elapsed edges.
  int          m_phase;
  int          m_n;
  int          m_clr;
  int          m_target;
  logic [15:0] m_lfsr;
  logic        m_btn;
  int          e_led, e_busy, e_result, e_rv, e_foul, e_to;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_n      = 0;
    m_clr    = 0;
    m_target = 0;
    m_lfsr   = 16'hACE1;
    m_btn    = 1'b0;
    e_led = 0; e_busy = 0; e_result = 0; e_rv = 0; e_foul = 0; e_to = 0;
  endtask

  task automatic model_step();
    logic press;
    int   ms;
    press = bus.button & ~m_btn;
    m_n++;
    ms = (m_n - 1 - m_clr) / TD;
    case (m_phase)
      P_WAIT: begin
        if (press) begin
          m_phase = P_FOUL; e_foul = 1; e_busy = 0;
        end else if (ms == m_target) begin
          m_phase = P_REACT; e_led = 1; m_clr = m_n;
        end
      end
      P_REACT: begin
        if (press) begin
          m_phase = P_DONE; e_result = ms; e_rv = 1; e_led = 0; e_busy = 0;
        end else if (ms == MAXR) begin
          m_phase = P_DONE; e_result = MAXR; e_rv = 1; e_to = 1; e_led = 0; e_busy = 0;
        end
      end
      default: begin
        if (bus.start) begin
          m_phase  = P_WAIT;
          m_clr    = m_n;
          m_target = MIND + (int'(m_lfsr) % (1 << RB));
          e_busy = 1; e_led = 0; e_result = 0; e_rv = 0; e_foul = 0; e_to = 0;
        end
      end
    endcase
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_btn  = bus.button;
  endtask

  task automatic check_all();
    int exp_a;
    int exp_b;
    exp_a = 0;
    exp_b = 0;
    if (m_phase == P_WAIT) begin
      exp_a = (m_n - m_clr) / TD;
      exp_b = m_target;
    end else if (m_phase == P_REACT) begin
      exp_a = (m_n - m_clr) / TD;
      exp_b = MAXR;
    end
    chk("m_led",    int'(bus.led),          e_led);
    chk("m_busy",   int'(bus.busy),         e_busy);
    chk("m_result", int'(bus.result),       e_result);
    chk("m_rv",     int'(bus.result_valid), e_rv);
    chk("m_foul",   int'(bus.foul),         e_foul);
    chk("m_to",     int'(bus.timeout),      e_to);
    chk("m_cmp_a",  int'(bus.cmp_a),        exp_a);
    chk("m_cmp_b",  int'(bus.cmp_b),        exp_b);
  endtask

  // Compare process: advance the model on every clock edge or reset, then check
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
      #1;
      check_all();
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_led(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.led) seen = 1'b1;
    end
    chk("led_rise", int'(seen), 1);
  endtask

  // Directed rounds
  initial begin
    bus.start  = 1'b0;
    bus.button = 1'b0;
    cyc(3);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_led",  int'(bus.led), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rv",   int'(bus.result_valid), 0);
    chk("idle_cmpb", int'(bus.cmp_b), 0);
    // lfsr has stepped once (ACE1 -> 59C3), so target = 3 + 3
    pulse_start();
    chk("start_busy", int'(bus.busy), 1);
    chk("target_6",   int'(bus.cmp_b), 6);
    chk("start_cmpa", int'(bus.cmp_a), 0);

    wait_led(100);
    cyc(28);
    bus.button = 1'b1;
    @(negedge clk);
    chk("norm_result", int'(bus.result), 7);
    chk("norm_rv",     int'(bus.result_valid), 1);
    chk("norm_led",    int'(bus.led), 0);
    chk("norm_foul",   int'(bus.foul), 0);
    chk("norm_to",     int'(bus.timeout), 0);
    cyc(2);
    bus.button = 1'b0;
    cyc(2);

    pulse_start();
    chk("clr_rv", int'(bus.result_valid), 0);
    cyc(4);
    bus.button = 1'b1;
    @(negedge clk);
    chk("foul_set",  int'(bus.foul), 1);
    chk("foul_busy", int'(bus.busy), 0);
    bus.button = 1'b0;
    cyc(40);
    chk("foul_noled", int'(bus.led), 0);
    chk("foul_norv",  int'(bus.result_valid), 0);

    pulse_start();
    chk("foul_clr", int'(bus.foul), 0);
    wait_led(100);
    cyc(80);
    chk("pre_to_rv", int'(bus.result_valid), 0);
    @(negedge clk);
    chk("to_flag",   int'(bus.timeout), 1);
    chk("to_result", int'(bus.result), 20);
    chk("to_rv",     int'(bus.result_valid), 1);
    chk("to_led",    int'(bus.led), 0);

    // Press lands on the same edge that sees ms_count == target
    pulse_start();
    cyc(TD * m_target);
    bus.button = 1'b1;
    @(negedge clk);
    chk("tie_wait_foul", int'(bus.foul), 1);
    chk("tie_wait_led",  int'(bus.led), 0);
    bus.button = 1'b0;
    cyc(3);

    pulse_start();
    wait_led(100);
    cyc(10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_start_led",  int'(bus.led), 1);
    chk("ign_start_busy", int'(bus.busy), 1);
    cyc(69);
    bus.button = 1'b1;
    @(negedge clk);
    chk("tie_react_result", int'(bus.result), 20);
    chk("tie_react_to",     int'(bus.timeout), 0);
    chk("tie_react_rv",     int'(bus.result_valid), 1);
    bus.button = 1'b0;
    cyc(3);

    pulse_start();
    wait_led(100);
    cyc(5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_led",  int'(bus.led), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_rv",   int'(bus.result_valid), 0);
    @(negedge clk);
    cyc(1);
    chk("rst_cmpa", int'(bus.cmp_a), 0);
    // Start on the first edge after release samples the seed: target = 3 + 1
    rst = 1'b0;
    pulse_start();
    chk("rst_busy2",    int'(bus.busy), 1);
    chk("target_seed4", int'(bus.cmp_b), 4);
    cyc(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
